// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: splits 32-bit words (1..4 valid bytes, LSB first) into
// single-byte writes for an 8-bit FIFO, honouring the FIFO full flag. Keeps a
// running count of written bytes and pulses err_len on malformed lengths.
module fifo_word_unpacker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_nbytes,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             fifo_full,
    output logic             fifo_wn,
    output logic [7:0]       fifo_din,
    output logic             err_len,
    output logic [CNT_W-1:0] bytes_written
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        shreg_q, shreg_d;
    logic [2:0]         remain_q, remain_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    // Lengths above 4 are clamped to a full word; zero means nothing to send.
    function automatic logic [2:0] eff_len(input logic [2:0] n);
        logic [2:0] r;
        case (n)
            3'd0:                      r = 3'd0;
            3'd1, 3'd2, 3'd3, 3'd4:    r = n;
            default:                   r = 3'd4;
        endcase
        return r;
    endfunction

    // A length is malformed when it is zero or exceeds four bytes.
    function automatic logic len_illegal(input logic [2:0] n);
        return (n == 3'd0) || (n > 3'd4);
    endfunction

    // Handshake and write strobes; ready early on the last byte allows back-to-back words.
    always_comb begin
        fifo_wn  = (state_q == SEND) && !fifo_full;
        in_ready = (state_q == IDLE) ||
                   ((state_q == SEND) && (remain_q == 3'd1) && !fifo_full);
        accept   = in_valid && in_ready;
        fifo_din = shreg_q[7:0];
        err_len  = err_q;
        bytes_written = cnt_q;
    end

    // Next-state: drain one byte per write, and a new word overrides the drain on accept.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;

        if (fifo_wn) begin
            shreg_d  = shreg_q >> 8;
            remain_d = remain_q - 3'd1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (remain_q == 3'd1) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            shreg_d  = in_data;
            remain_d = eff_len(in_nbytes);
            err_d    = len_illegal(in_nbytes);
            state_d  = (eff_len(in_nbytes) == 3'd0) ? IDLE : SEND;
        end
    end

    // State register; reset drops any partially sent word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            remain_q <= remain_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Testbench for fifo_word_unpacker: directed scenarios with literal expectations
// plus randomized words and backpressure checked against a byte-queue model.
module tb_fifo_word_unpacker;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [31:0]      in_data;
    logic [2:0]       in_nbytes;
    logic             in_valid;
    logic             in_ready;
    logic             fifo_full;
    logic             fifo_wn;
    logic [7:0]       fifo_din;
    logic             err_len;
    logic [CNT_W-1:0] bytes_written;

    fifo_word_unpacker #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_nbytes     (in_nbytes),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fifo_full     (fifo_full),
        .fifo_wn       (fifo_wn),
        .fifo_din      (fifo_din),
        .err_len       (err_len),
        .bytes_written (bytes_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nerr  = 0;
    bit chk_en = 0;

    // Behavioural model: bytes still owed to the FIFO, count, pending error pulse.
    logic [7:0]       mq[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_err = 1'b0;

    // Observation log used by directed tests.
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         errcnt = 0;
    int         cycn   = 0;

    bit rand_full   = 0;
    bit forced_full = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge from the specification's rules.
    always @(posedge clk) begin
        bit wr, rdy, acc;
        int eff;
        if (rst) begin
            mq.delete();
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            wr  = (mq.size() > 0) && !fifo_full;
            rdy = (mq.size() == 0) || ((mq.size() == 1) && !fifo_full);
            acc = in_valid && rdy;
            if (wr) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            m_err = acc && ((in_nbytes == 0) || (in_nbytes > 4));
            if (acc) begin
                eff = (in_nbytes > 4) ? 4 : int'(in_nbytes);
                for (int i = 0; i < eff; i++) mq.push_back(in_data[8*i +: 8]);
            end
        end
    end

    // Compare and monitor, mid-cycle.
    always @(negedge clk) begin
        bit ewn, erdy;
        cycn++;
        if (fifo_wn === 1'b1) begin
            wlog.push_back(fifo_din);
            wcyc.push_back(cycn);
        end
        if (err_len === 1'b1) errcnt++;
        if (chk_en) begin
            ewn  = (mq.size() > 0) && !fifo_full;
            erdy = (mq.size() == 0) || ((mq.size() == 1) && !fifo_full);
            chk("fifo_wn", 32'(fifo_wn), 32'(ewn));
            chk("in_ready", 32'(in_ready), 32'(erdy));
            chk("err_len", 32'(err_len), 32'(m_err));
            chk("bytes_written", 32'(bytes_written), 32'(m_cnt));
            if (ewn) chk("fifo_din", 32'(fifo_din), 32'(mq[0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : forced_full;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present a word and hold it until accepted; leaves in_valid high.
    task automatic send(input logic [31:0] d, input logic [2:0] nb);
        bit acc;
        int t;
        in_data   = d;
        in_nbytes = nb;
        in_valid  = 1'b1;
        t = 0;
        do begin
            #1;
            acc = in_ready;
            cyc();
            t++;
        end while (!acc && t < 100);
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: got not-accepted, expected accepted within 100 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic clr_log();
        wlog.delete();
        wcyc.delete();
        errcnt = 0;
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_nwrites"}, 32'(wlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            chk({name, "_byte"}, 32'(wlog[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] e[$];
        logic [31:0] d;
        logic [2:0]  nb;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_nbytes = '0;
        fifo_full = 1'b0;
        cyc();
        chk_en = 1;
        cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_fifo_din", 32'(fifo_din), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_fifo_wn", 32'(fifo_wn), 32'h0);
        chk("rst_bytes_written", 32'(bytes_written), 32'h0);

        // Single word, 4 bytes
        clr_log();
        send(32'hDDCCBBAA, 3'd4);
        idle(6);
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk_log("single", e);
        chk("single_count", 32'(bytes_written), 32'd4);

        // Short word, 2 bytes
        do_reset();
        clr_log();
        send(32'h11223344, 3'd2);
        idle(4);
        e = '{8'h44, 8'h33};
        chk_log("short", e);
        chk("short_err", 32'(errcnt), 32'd0);

        // Back-to-back
        do_reset();
        clr_log();
        send(32'h03020100, 3'd4);
        send(32'h07060504, 3'd4);
        idle(8);
        e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        chk_log("b2b", e);
        if (wcyc.size() == 8) chk("b2b_span", 32'(wcyc[7] - wcyc[0]), 32'd7);

        // Backpressure: full for 3 cycles after the second byte
        do_reset();
        clr_log();
        send(32'hDDCCBBAA, 3'd4);
        cyc();
        forced_full = 1;
        cyc();
        cyc();
        cyc();
        forced_full = 0;
        idle(4);
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk_log("bp", e);
        if (wcyc.size() == 4) chk("bp_span", 32'(wcyc[3] - wcyc[0]), 32'd6);
        chk("bp_count", 32'(bytes_written), 32'd4);

        // Illegal lengths
        do_reset();
        clr_log();
        send(32'h55667788, 3'd0);
        idle(3);
        chk("len0_nwrites", 32'(wlog.size()), 32'd0);
        chk("len0_err", 32'(errcnt), 32'd1);
        clr_log();
        send(32'hDDCCBBAA, 3'd6);
        idle(6);
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk_log("len6", e);
        chk("len6_err", 32'(errcnt), 32'd1);

        // Reset mid-word
        do_reset();
        clr_log();
        send(32'hDDCCBBAA, 3'd4);
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_count", 32'(bytes_written), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        idle(3);
        chk("midrst_nwrites", 32'(wlog.size()), 32'd2);
        clr_log();
        send(32'h44332211, 3'd3);
        idle(5);
        e = '{8'h11, 8'h22, 8'h33};
        chk_log("after_rst", e);

        // Randomized words with random backpressure
        rand_full = 1;
        for (int w = 0; w < 300; w++) begin
            d  = $urandom();
            nb = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) nb = 3'd0;
            send(d, nb);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        idle(10);
        rand_full = 0;
        forced_full = 0;
        idle(4);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Upstream feeder for the 8-deep x 8-bit FIFO. It accepts 32-bit words on a valid/ready interface and splits each word into up to four bytes, LSB first. It writes the bytes into the FIFO one per cycle, honouring the FIFO `full` flag. It also maintains a byte counter and flags malformed length fields.

## Interface
- `CNT_W`, default 16: width of the `bytes_written` counter.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  32  word to unpack; byte 0 = `in_data[7:0]`, sent first.
- `in_nbytes`  in  3  number of valid bytes in `in_data`; legal values are 1..4.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `fifo_full`  in  1  FIFO `full` flag, combinational from FIFO pointers.
- `fifo_wn`  out  1  FIFO write enable.
- `fifo_din`  out  8  FIFO write data.
- `err_len`  out  1  one-cycle pulse: illegal `in_nbytes` on an accepted word.
- `bytes_written`  out  CNT_W  count of bytes written (`fifo_wn` cycles); wraps modulo 2^CNT_W.

## Operation
- **States:**
  - `IDLE`: no bytes pending.
  - `SEND`: bytes pending in the 32-bit shift register `shreg`, with a 3-bit `remain` count.
- **Accept:** an accepted word is one where `in_valid & in_ready` is high at a rising edge.
- **On accept:**
  - `shreg <= in_data`.
  - `remain <= eff_n`, where `eff_n` is:
    - `in_nbytes` if it is in 1..4;
    - 4 if it is in 5..7;
    - 0 if it is 0.
  - If `eff_n` = 0, the state stays `IDLE`. Otherwise the state goes to `SEND`.
- **err_len:** registered. It is 1 in the cycle after accepting a word with `in_nbytes` of 0 or 5..7. It is 0 otherwise.
- **Write outputs (combinational):**
  - `fifo_wn = (state == SEND) & !fifo_full`.
  - `fifo_din = shreg[7:0]`.
- **On each edge with `fifo_wn` = 1:**
  - `shreg <= shreg >> 8`.
  - `remain <= remain - 1`.
  - `bytes_written <= bytes_written + 1`.
- **End of word:** when `remain` = 1 and a write occurs, the state returns to `IDLE`. The exception is a simultaneous accept, which reloads per the accept rules above (back-to-back).
- **in_ready** is combinational: `(state == IDLE) | (state == SEND & remain == 1 & !fifo_full)`.
- **Stall:** while `fifo_full` = 1 in `SEND`:
  - `fifo_wn` = 0;
  - `shreg`, `remain` and the counter hold;
  - `in_ready` = 0.
- **Write priority:** the FIFO gives writes priority over reads. This block never asserts `fifo_wn` while `fifo_full` = 1.
- **Upstream contract:** `in_data` and `in_nbytes` must be held stable while `in_valid` = 1 and `in_ready` = 0.
- **Reset mid-operation:** `rst` = 1 discards any partially sent word. Unsent bytes are lost and nothing further is written.

## Timing
- **Reset values** (in the cycle after an edge with `rst` = 1):
  - state `IDLE`, `shreg` 0, `remain` 0;
  - `fifo_wn` 0, `fifo_din` 0x00, `err_len` 0, `bytes_written` 0;
  - `in_ready` 1.
- **Latency:** the first byte is on `fifo_din` with `fifo_wn` = 1 in the cycle after the accept edge, if `fifo_full` = 0.
- **Throughput:** N bytes take N cycles with no stalls. With back-to-back words, `fifo_wn` stays high continuously.
- **fifo_full timing:** `fifo_full` is sampled in the same cycle that drives `fifo_wn`. A stall costs exactly the cycles in which `fifo_full` = 1.
- **Reset vs. in_valid:** reset takes priority over any simultaneous `in_valid`. No word is accepted on a reset edge.

## Test plan
- **Single word:** reset, then `in_data` = 0xDDCCBBAA, `in_nbytes` = 4, one-cycle valid.
  - `fifo_wn` is high for cycles 1-4 with `fifo_din` AA, BB, CC, DD.
  - `bytes_written` = 4; `in_ready` is high in cycle 4.
- **Short word:** `in_nbytes` = 2, `in_data` = 0x11223344.
  - Exactly 2 writes: 44 then 33.
  - `err_len` stays 0; the state is `IDLE` after 2 cycles.
- **Back-to-back:** 0x03020100/4 followed by 0x07060504/4 with `in_valid` held high.
  - 8 consecutive `fifo_wn` cycles, bytes 00..07.
  - `in_ready` is high only in cycles 0 and 4.
- **Backpressure:** `fifo_full` forced to 1 for 3 cycles after the second byte of a 4-byte word.
  - `fifo_wn` = 0 for those 3 cycles; the third byte resumes unchanged.
  - Total 7 cycles; `bytes_written` = 4.
- **Illegal length:**
  - `in_nbytes` = 0: no writes, and `err_len` pulses once.
  - `in_nbytes` = 6 with 0xDDCCBBAA: 4 writes AA..DD, and `err_len` pulses once.
- **Reset mid-word:** `rst` asserted after 2 of 4 bytes.
  - No further writes; `bytes_written` = 0 and `in_ready` = 1 the next cycle.
  - A new word sends correctly afterwards.
